// File: rtl/spi_ram_ctrl_if.sv
// Command/response bus between an SPI front end and spi_ram_ctrl.
// The master side issues commands and acknowledges read data. The slave side is the controller.
interface spi_ram_ctrl_if #(
   parameter int DATA_W = 8
);
   logic              rx_valid;
   logic [DATA_W+1:0] din;
   logic              tx_ack;
   logic              err_clr;
   logic              tx_valid;
   logic [DATA_W-1:0] dout;
   logic              addr_err;
   logic              overrun;

   modport master (
      output rx_valid, din, tx_ack, err_clr,
      input  tx_valid, dout, addr_err, overrun
   );

   modport slave (
      input  rx_valid, din, tx_ack, err_clr,
      output tx_valid, dout, addr_err, overrun
   );
endinterface

// File: rtl/spi_ram_ctrl.sv
// Word-addressed RAM behind a command stream. It keeps separate write and read pointers and holds one read result until it is acknowledged.
// Optional feature: define SPI_RAM_AUTOINC_EN to post-increment the pointers on data commands.
module spi_ram_ctrl #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,   // must not exceed DATA_W: the address comes from the payload
   parameter int MEM_DEPTH = 256
) (
   input  logic         clk,
   input  logic         rst_n,
   spi_ram_ctrl_if.slave bus
);

`ifdef SPI_RAM_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   typedef enum logic [1:0] {
      OP_LD_WR = 2'b00,
      OP_WR    = 2'b01,
      OP_LD_RD = 2'b10,
      OP_RD    = 2'b11
   } op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } state_e;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return 32'(a) < 32'(MEM_DEPTH);
   endfunction

   // The last valid word wraps to 0, and so does any out-of-range pointer.
   function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] a);
      if (32'(a) >= 32'(MEM_DEPTH - 1)) return '0;
      return a + 1'b1;
   endfunction

   state_e              r_state;
   logic [DATA_W-1:0]   r_dout;
   logic [ADDR_W-1:0]   r_addr_wr;
   logic [ADDR_W-1:0]   r_addr_rd;
   logic                r_addr_err;
   logic                r_overrun;
   logic [DATA_W-1:0]   r_mem [MEM_DEPTH];

   op_e                 w_op;
   logic [DATA_W-1:0]   w_payload;
   logic [ADDR_W-1:0]   w_addr_in;
   logic                w_rd_cmd;
   state_e              w_state_nxt;
   logic                w_rd_accept;
   logic                w_rd_drop;
   logic                w_mem_we;
   logic                w_addr_err_set;
   logic [ADDR_W-1:0]   w_addr_wr_nxt;
   logic [ADDR_W-1:0]   w_addr_rd_nxt;
   logic [IDX_W-1:0]    w_wr_idx;
   logic [IDX_W-1:0]    w_rd_idx;
   logic [DATA_W-1:0]   w_rd_data;

   assign w_op      = op_e'(bus.din[DATA_W+1:DATA_W]);
   assign w_payload = bus.din[DATA_W-1:0];
   assign w_addr_in = w_payload[ADDR_W-1:0];
   assign w_rd_cmd  = bus.rx_valid && (w_op == OP_RD);

   // Truncation is exact whenever the pointer is in range, and out-of-range accesses are gated.
   assign w_wr_idx  = r_addr_wr[IDX_W-1:0];
   assign w_rd_idx  = r_addr_rd[IDX_W-1:0];
   assign w_rd_data = in_range(r_addr_rd) ? r_mem[w_rd_idx] : '0;

   // NOTE: every signal assigned below gets a default first, so no latch can be inferred.
   always_comb begin
      w_state_nxt    = r_state;
      w_rd_accept    = 1'b0;
      w_rd_drop      = 1'b0;
      w_mem_we       = 1'b0;
      w_addr_err_set = 1'b0;
      w_addr_wr_nxt  = r_addr_wr;
      w_addr_rd_nxt  = r_addr_rd;

      case (r_state)
         S_IDLE: begin
            if (w_rd_cmd) begin
               w_rd_accept = 1'b1;
               w_state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (bus.tx_ack) begin
               if (w_rd_cmd) w_rd_accept = 1'b1;
               else          w_state_nxt = S_IDLE;
            end else if (w_rd_cmd) begin
               w_rd_drop = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (bus.rx_valid) begin
         case (w_op)
            OP_LD_WR: begin
               w_addr_wr_nxt  = w_addr_in;
               w_addr_err_set = !in_range(w_addr_in);
            end
            OP_WR: begin
               // rst_n gates the write: the RAM has no reset, and commands must not land during reset.
               w_mem_we = rst_n && in_range(r_addr_wr);
               if (AUTOINC) w_addr_wr_nxt = ptr_inc(r_addr_wr);
            end
            OP_LD_RD: begin
               w_addr_rd_nxt  = w_addr_in;
               w_addr_err_set = !in_range(w_addr_in);
            end
            OP_RD: begin
               if (AUTOINC && w_rd_accept) w_addr_rd_nxt = ptr_inc(r_addr_rd);
            end
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_dout     <= '0;
         r_addr_wr  <= '0;
         r_addr_rd  <= '0;
         r_addr_err <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_addr_wr <= w_addr_wr_nxt;
         r_addr_rd <= w_addr_rd_nxt;
         if (w_rd_accept) r_dout <= w_rd_data;

         if (w_addr_err_set)   r_addr_err <= 1'b1;
         else if (bus.err_clr) r_addr_err <= 1'b0;

         if (w_rd_drop)        r_overrun <= 1'b1;
         else if (bus.err_clr) r_overrun <= 1'b0;
      end
   end

   // NOTE: the memory array is deliberately not reset. Its contents survive rst_n.
   always_ff @(posedge clk) begin
      if (w_mem_we) r_mem[w_wr_idx] <= w_payload;
   end

   assign bus.tx_valid = (r_state == S_HOLD);
   assign bus.dout     = r_dout;
   assign bus.addr_err = r_addr_err;
   assign bus.overrun  = r_overrun;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl with MEM_DEPTH=200. It applies a per-cycle vector table, then runs sequences for reset and pointer behaviour.
// The pointer-sequence expectations follow whether SPI_RAM_AUTOINC_EN is defined.
module tb_spi_ram_ctrl;

   typedef struct {
      logic       v;
      logic [1:0] op;
      logic [7:0] pl;
      logic       ack;
      logic       clr;
      logic       e_tv;
      logic [7:0] e_do;
      logic       e_ae;
      logic       e_ov;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   spi_ram_ctrl_if #(.DATA_W(8)) bus ();

   spi_ram_ctrl #(
      .DATA_W   (8),
      .ADDR_W   (8),
      .MEM_DEPTH(200)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   function automatic vec_t mk(int v, int op, int pl, int ack, int clr,
                               int tv, int dout, int ae, int ov);
      vec_t m;
      m.v = v[0]; m.op = op[1:0]; m.pl = pl[7:0]; m.ack = ack[0]; m.clr = clr[0];
      m.e_tv = tv[0]; m.e_do = dout[7:0]; m.e_ae = ae[0]; m.e_ov = ov[0];
      return m;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one command for one clock. Outputs are sampled 1 time unit after the edge.
   task automatic step(input int v, input int op, input int pl, input int ack, input int clr);
      bus.rx_valid = v[0];
      bus.din      = {op[1:0], pl[7:0]};
      bus.tx_ack   = ack[0];
      bus.err_clr  = clr[0];
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input int tv, input int dout, input int ae, input int ov);
      check({tag, ".tx_valid"}, 8'(bus.tx_valid), 8'(tv));
      check({tag, ".dout"},     bus.dout,          8'(dout));
      check({tag, ".addr_err"}, 8'(bus.addr_err), 8'(ae));
      check({tag, ".overrun"},  8'(bus.overrun),  8'(ov));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      //               v op  pl  ack clr  tv dout  ae ov
      vecs.push_back(mk(1, 0, 'h05, 0, 0,  0, 'h00, 0, 0));
      vecs.push_back(mk(1, 1, 'hA5, 0, 0,  0, 'h00, 0, 0));
      vecs.push_back(mk(1, 2, 'h05, 0, 0,  0, 'h00, 0, 0));
      vecs.push_back(mk(1, 3, 'h00, 0, 0,  1, 'hA5, 0, 0));
      vecs.push_back(mk(0, 0, 'h00, 1, 0,  0, 'hA5, 0, 0));
      vecs.push_back(mk(0, 0, 'h00, 1, 0,  0, 'hA5, 0, 0));
      vecs.push_back(mk(1, 0, 'h10, 0, 0,  0, 'hA5, 0, 0));
      vecs.push_back(mk(1, 1, 'h5A, 0, 0,  0, 'hA5, 0, 0));
      vecs.push_back(mk(1, 2, 'h10, 0, 0,  0, 'hA5, 0, 0));
      vecs.push_back(mk(1, 3, 'h00, 0, 0,  1, 'h5A, 0, 0));
      vecs.push_back(mk(1, 2, 'h05, 0, 0,  1, 'h5A, 0, 0));
      vecs.push_back(mk(1, 3, 'h00, 0, 0,  1, 'h5A, 0, 1));
      vecs.push_back(mk(1, 3, 'h00, 1, 0,  1, 'hA5, 0, 1));
      vecs.push_back(mk(0, 0, 'h00, 0, 1,  1, 'hA5, 0, 0));
      vecs.push_back(mk(0, 0, 'h00, 1, 0,  0, 'hA5, 0, 0));
      vecs.push_back(mk(1, 0, 'hC8, 0, 0,  0, 'hA5, 1, 0));
      vecs.push_back(mk(1, 1, 'h3C, 0, 0,  0, 'hA5, 1, 0));
      vecs.push_back(mk(1, 2, 'hC8, 0, 0,  0, 'hA5, 1, 0));
      vecs.push_back(mk(1, 3, 'h00, 0, 0,  1, 'h00, 1, 0));
      vecs.push_back(mk(0, 0, 'h00, 1, 1,  0, 'h00, 0, 0));
      vecs.push_back(mk(1, 2, 'hC8, 0, 1,  0, 'h00, 1, 0));
      vecs.push_back(mk(0, 0, 'h00, 0, 1,  0, 'h00, 0, 0));
      vecs.push_back(mk(1, 0, 'hC7, 0, 0,  0, 'h00, 0, 0));
      vecs.push_back(mk(1, 1, 'h77, 0, 0,  0, 'h00, 0, 0));
      vecs.push_back(mk(1, 2, 'hC7, 0, 0,  0, 'h00, 0, 0));
      vecs.push_back(mk(1, 3, 'h00, 0, 0,  1, 'h77, 0, 0));
      vecs.push_back(mk(1, 3, 'h00, 0, 1,  1, 'h77, 0, 1));
      vecs.push_back(mk(0, 0, 'h00, 0, 1,  1, 'h77, 0, 0));
      vecs.push_back(mk(1, 0, 'h30, 1, 0,  0, 'h77, 0, 0));

      rst_n        = 1'b0;
      bus.rx_valid = 1'b0;
      bus.din      = '0;
      bus.tx_ack   = 1'b0;
      bus.err_clr  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 0, 'h00, 0, 0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].v, vecs[i].op, vecs[i].pl, vecs[i].ack, vecs[i].clr);
         check_all($sformatf("vec%0d", i), vecs[i].e_tv, vecs[i].e_do, vecs[i].e_ae, vecs[i].e_ov);
      end

      // An asynchronous reset in HOLD clears the outputs before the next edge, and RAM contents survive it.
      step(1, 0, 'h00, 0, 0);
      step(1, 1, 'h44, 0, 0);
      step(1, 0, 'h20, 0, 0);
      step(1, 1, 'h99, 0, 0);
      step(1, 2, 'h20, 0, 0);
      step(1, 3, 'h00, 0, 0);
      check("pre_rst.tx_valid", 8'(bus.tx_valid), 8'd1);
      check("pre_rst.dout",     bus.dout,          8'h99);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("async_rst", 0, 'h00, 0, 0);
      // This write of 0x55 to address 0 is issued during reset and must be ignored.
      bus.rx_valid = 1'b1;
      bus.din      = {2'b01, 8'h55};
      repeat (2) @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
      rst_n        = 1'b1;
      step(1, 2, 'h20, 0, 0);
      step(1, 3, 'h00, 0, 0);
      check("post_rst.tx_valid", 8'(bus.tx_valid), 8'd1);
      check("post_rst.dout",     bus.dout,          8'h99);
      step(0, 0, 'h00, 1, 0);
      step(1, 2, 'h00, 0, 0);
      step(1, 3, 'h00, 0, 0);
      check("rst_cmd_ignored.dout", bus.dout, 8'h44);
      step(0, 0, 'h00, 1, 0);
      check("rst_seq.tx_valid", 8'(bus.tx_valid), 8'd0);

`ifdef SPI_RAM_AUTOINC_EN
      // The pointers wrap from the last word (0xC7) to address 0.
      step(1, 0, 'hC7, 0, 0);
      step(1, 1, 'h11, 0, 0);
      step(1, 1, 'h22, 0, 0);
      step(1, 2, 'hC7, 0, 0);
      step(1, 3, 'h00, 0, 0);
      check("burst0.dout", bus.dout, 8'h11);
      step(1, 3, 'h00, 1, 0);
      check("burst1.dout",     bus.dout,          8'h22);
      check("burst1.tx_valid", 8'(bus.tx_valid), 8'd1);
      check("burst1.overrun",  8'(bus.overrun),  8'd0);
`else
      // Without auto-increment, both data commands keep reusing the same address.
      step(1, 0, 'h40, 0, 0);
      step(1, 1, 'h11, 0, 0);
      step(1, 1, 'h22, 0, 0);
      step(1, 2, 'h40, 0, 0);
      step(1, 3, 'h00, 0, 0);
      check("noinc0.dout", bus.dout, 8'h22);
      step(1, 3, 'h00, 1, 0);
      check("noinc1.dout",     bus.dout,          8'h22);
      check("noinc1.tx_valid", 8'(bus.tx_valid), 8'd1);
      check("noinc1.overrun",  8'(bus.overrun),  8'd0);
`endif
      step(0, 0, 'h00, 1, 0);
      check("final.tx_valid", 8'(bus.tx_valid), 8'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
